fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 16: width of PC and Target.
REQ-002 Parameter MAX_CYC, default 16'hFFFF: cycle limit before forced timeout.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request to begin a program; sampled only in IDLE or DONE.
REQ-006 ProgSel  input  2  program select: 0 = P1, 1 = P2, 2 = P3, 3 = invalid.
REQ-007 Instruction  input  9  currently fetched machine word; opcode is bits [8:5].
REQ-008 jump_en  input  1  taken-branch indication from control decoder.
REQ-009 Target  input  PC_W  branch destination from control decoder, valid when jump_en = 1.
REQ-010 MemWait  input  1  current instruction needs another cycle; hold PC.
REQ-011 PC  output  PC_W  instruction ROM address.
REQ-012 Busy  output  1  high in RUN.
REQ-013 Done  output  1  high in DONE (a level, not a pulse).
REQ-014 Timeout  output  1  high in DONE when entry was caused by the cycle limit.
REQ-015 CycleCount  output  16  RUN cycles executed since the last accepted Start.
REQ-016 JumpCount  output  8  taken jumps since the last accepted Start; saturates at 8'hFF.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE: PC SHALL be held; Start = 1 with ProgSel 0–2 SHALL load PC from the selected start address, clear all counters and Timeout, and enter RUN on the next edge.
REQ-019 ProgSel = 3 with Start SHALL be ignored; the FSM stays in its current state and PC is unchanged.
REQ-020 RUN SHALL evaluate the following in priority order, highest first:
- halt (opcode == kHALT) -> DONE, PC held;
- CycleCount == MAX_CYC -> DONE with Timeout = 1;
- MemWait -> PC held;
- jump_en -> PC = Target and JumpCount + 1;
- otherwise PC = PC + 1.
REQ-021 CycleCount SHALL increment on every RUN cycle, including stall cycles and the halt cycle.
REQ-022 PC + 1 SHALL wrap modulo 2^PC_W, so 16'hFFFF becomes 16'h0000.
REQ-023 Start SHALL be ignored in RUN.
REQ-024 Start in DONE SHALL behave exactly as in IDLE.
REQ-025 DONE SHALL hold PC, the counters and Timeout until Start is accepted.
REQ-026 jump_en and MemWait SHALL have no effect outside RUN.
REQ-027 The PC update SHALL take effect one cycle after the decision (registered PC), with no combinational path from inputs to PC.

Reset
REQ-028 Reset = 1 SHALL immediately force the state to IDLE, PC = 0, CycleCount = 0, JumpCount = 0 and Timeout = 0, which gives Busy = 0 and Done = 0.
REQ-029 Reset asserted mid-RUN SHALL abort the program; no Done SHALL be produced.
REQ-030 After Reset deasserts, the block SHALL wait in IDLE for Start.

Structure
REQ-031 The definitions package SHALL hold the following:
- kHALT opcode;
- kP1_START = 16'h0000, kP2_START = 16'h0080, kP3_START = 16'h0100;
- the state enum typedef.
REQ-032 JumpCount SHALL be implemented in one sub-module, sat_counter (width-parameterised saturating counter with clear and enable).
REQ-033 All registers SHALL reside in a single clocked process with asynchronous reset; next-state and PC logic SHALL be combinational.

Verification
REQ-034 Reset, then Start with ProgSel = 1 -> PC = 16'h0080 and Busy = 1 the next cycle; PC counts 0081, 0082 on following cycles.
REQ-035 In RUN at PC = 0x0085, jump_en = 1 with Target = 16'h0f03 -> PC = 0x0f03 next cycle; JumpCount = 1.
REQ-036 MemWait high for 3 RUN cycles at PC = 0x0010 -> PC stays 0x0010 for 3 cycles; CycleCount still advances by 3.
REQ-037 kHALT opcode together with jump_en = 1 and MemWait = 1 -> DONE with PC unchanged, Done = 1, Timeout = 0, JumpCount unchanged.
REQ-038 MAX_CYC = 5 with no halt -> Done = 1 and Timeout = 1 after CycleCount reaches 5; a later Start with ProgSel = 2 -> PC = 0x0100 and Timeout = 0.
REQ-039 Reset pulsed mid-RUN at PC = 0x0042 -> PC = 0 and Busy = 0 immediately, without waiting for a clock edge; Start with ProgSel = 3 afterwards -> remains IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: halt opcode, program entry points,
// FSM state encoding and the program-select decode.
package fetch_sequencer_pkg;

  localparam logic [3:0]  kHALT     = 4'hF;
  localparam logic [15:0] kP1_START = 16'h0000;
  localparam logic [15:0] kP2_START = 16'h0080;
  localparam logic [15:0] kP3_START = 16'h0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ProgSel 3 is rejected before this is called; it maps to P1 only to stay total.
  function automatic logic [15:0] start_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    start_addr = kP2_START;
      2'd2:    start_addr = kP3_START;
      default: start_addr = kP1_START;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic of a saturating up-counter with clear and enable; the count
// register itself lives in the owning module's clocked process.
module sat_counter #(
  parameter int W = 8
) (
  input  logic [W-1:0] count,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] next
);

  always_comb begin
    next = count;
    if (clr)
      next = '0;
    else if (en && (count != '1))
      next = count + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program fetch sequencer: IDLE -> RUN -> DONE, driving the instruction ROM address
// with stall, branch, halt and cycle-limit handling.
//
// state | meaning
// IDLE  | after reset, PC held, waiting for Start
// RUN   | fetching; PC advances, stalls or branches each cycle
// DONE  | program ended by halt or cycle limit; results held until Start
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          PC_W    = 16,
  parameter logic [15:0] MAX_CYC = 16'hFFFF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [1:0]      ProgSel,
  input  logic [8:0]      Instruction,
  input  logic            jump_en,
  input  logic [PC_W-1:0] Target,
  input  logic            MemWait,
  output logic [PC_W-1:0] PC,
  output logic            Busy,
  output logic            Done,
  output logic            Timeout,
  output logic [15:0]     CycleCount,
  output logic [7:0]      JumpCount
);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [15:0]     cyc, cyc_n;
  logic [7:0]      jmp, jmp_n;
  logic            tmo, tmo_n;
  logic            jmp_clr, jmp_inc;
  logic            unused_instr;

  assign unused_instr = ^Instruction[4:0];

  sat_counter #(.W(8)) u_jump_cnt (
    .count (jmp),
    .clr   (jmp_clr),
    .en    (jmp_inc),
    .next  (jmp_n)
  );

  // The cycle-limit exit executes no instruction, so it leaves CycleCount at MAX_CYC.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cyc_n   = cyc;
    tmo_n   = tmo;
    jmp_clr = 1'b0;
    jmp_inc = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start && (ProgSel != 2'd3)) begin
          state_n = RUN;
          pc_n    = PC_W'(start_addr(ProgSel));
          cyc_n   = '0;
          tmo_n   = 1'b0;
          jmp_clr = 1'b1;
        end
      end
      RUN: begin
        if (Instruction[8:5] == kHALT) begin
          state_n = DONE;
          cyc_n   = cyc + 16'd1;
        end else if (cyc == MAX_CYC) begin
          state_n = DONE;
          tmo_n   = 1'b1;
        end else begin
          cyc_n = cyc + 16'd1;
          if (!MemWait) begin
            if (jump_en) begin
              pc_n    = Target;
              jmp_inc = 1'b1;
            end else begin
              pc_n = pc + PC_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      cyc   <= '0;
      jmp   <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cyc   <= cyc_n;
      jmp   <= jmp_n;
      tmo   <= tmo_n;
    end
  end

  assign PC         = pc;
  assign Busy       = (state == RUN);
  assign Done       = (state == DONE);
  assign Timeout    = tmo;
  assign CycleCount = cyc;
  assign JumpCount  = jmp;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table on the default-limit instance
// plus hand sequences for saturation, cycle-limit timeout and asynchronous reset.
module tb_fetch_sequencer;

  localparam logic [8:0] H = 9'h1E0;

  logic        Clk, Reset, Start, jump_en, MemWait;
  logic [1:0]  ProgSel;
  logic [8:0]  Instruction;
  logic [15:0] Target;

  logic [15:0] pc_a, cyc_a, pc_b, cyc_b;
  logic [7:0]  jc_a, jc_b;
  logic        busy_a, done_a, tmo_a, busy_b, done_b, tmo_b;

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .Instruction(Instruction), .jump_en(jump_en), .Target(Target), .MemWait(MemWait),
    .PC(pc_a), .Busy(busy_a), .Done(done_a), .Timeout(tmo_a),
    .CycleCount(cyc_a), .JumpCount(jc_a)
  );

  fetch_sequencer #(.PC_W(16), .MAX_CYC(16'd5)) dut_lim (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .Instruction(Instruction), .jump_en(jump_en), .Target(Target), .MemWait(MemWait),
    .PC(pc_b), .Busy(busy_b), .Done(done_b), .Timeout(tmo_b),
    .CycleCount(cyc_b), .JumpCount(jc_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic [8:0]  instr;
    logic        jmp;
    logic [15:0] tgt;
    logic        mw;
    logic [15:0] pc;
    logic        busy;
    logic        done;
    logic        tmo;
    logic [15:0] cyc;
    logic [7:0]  jc;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t v(input logic s, input logic [1:0] sel, input logic [8:0] ins,
                             input logic j, input logic [15:0] t, input logic m,
                             input logic [15:0] pc, input logic b, input logic d,
                             input logic to, input logic [15:0] c, input logic [7:0] jc);
    vec_t r;
    r.start = s; r.sel = sel; r.instr = ins; r.jmp = j; r.tgt = t; r.mw = m;
    r.pc = pc; r.busy = b; r.done = d; r.tmo = to; r.cyc = c; r.jc = jc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] sel, input logic [8:0] ins,
                       input logic j, input logic [15:0] t, input logic m);
    Start = s; ProgSel = sel; Instruction = ins; jump_en = j; Target = t; MemWait = m;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [15:0] pc, input logic b, input logic d,
                       input logic to, input logic [15:0] c, input logic [7:0] jc);
    chk({nm, ".pc"},   pc_a,   pc);
    chk({nm, ".busy"}, busy_a, b);
    chk({nm, ".done"}, done_a, d);
    chk({nm, ".tmo"},  tmo_a,  to);
    chk({nm, ".cyc"},  cyc_a,  c);
    chk({nm, ".jc"},   jc_a,   jc);
  endtask

  task automatic chk_b(input string nm, input logic [15:0] pc, input logic b, input logic d,
                       input logic to, input logic [15:0] c);
    chk({nm, ".pc"},   pc_b,   pc);
    chk({nm, ".busy"}, busy_b, b);
    chk({nm, ".done"}, done_b, d);
    chk({nm, ".tmo"},  tmo_b,  to);
    chk({nm, ".cyc"},  cyc_b,  c);
  endtask

  initial begin
    vecs[0]  = v(0, 0, 9'h000, 1, 16'h1234, 1, 16'h0000, 0, 0, 0, 16'd0,  8'd0);
    vecs[1]  = v(1, 3, 9'h000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'd0,  8'd0);
    vecs[2]  = v(1, 1, 9'h000, 0, 16'h0000, 0, 16'h0080, 1, 0, 0, 16'd0,  8'd0);
    vecs[3]  = v(0, 0, 9'h000, 0, 16'h0000, 0, 16'h0081, 1, 0, 0, 16'd1,  8'd0);
    vecs[4]  = v(0, 0, 9'h000, 0, 16'h0000, 0, 16'h0082, 1, 0, 0, 16'd2,  8'd0);
    vecs[5]  = v(1, 0, 9'h000, 0, 16'h0000, 0, 16'h0083, 1, 0, 0, 16'd3,  8'd0);
    vecs[6]  = v(0, 0, 9'h000, 0, 16'h0000, 0, 16'h0084, 1, 0, 0, 16'd4,  8'd0);
    vecs[7]  = v(0, 0, 9'h000, 0, 16'h0000, 0, 16'h0085, 1, 0, 0, 16'd5,  8'd0);
    vecs[8]  = v(0, 0, 9'h000, 1, 16'h0f03, 0, 16'h0f03, 1, 0, 0, 16'd6,  8'd1);
    vecs[9]  = v(0, 0, 9'h000, 1, 16'h0010, 0, 16'h0010, 1, 0, 0, 16'd7,  8'd2);
    vecs[10] = v(0, 0, 9'h000, 0, 16'h0000, 1, 16'h0010, 1, 0, 0, 16'd8,  8'd2);
    vecs[11] = v(0, 0, 9'h000, 0, 16'h0000, 1, 16'h0010, 1, 0, 0, 16'd9,  8'd2);
    vecs[12] = v(0, 0, 9'h000, 0, 16'h0000, 1, 16'h0010, 1, 0, 0, 16'd10, 8'd2);
    vecs[13] = v(0, 0, 9'h000, 1, 16'h0777, 1, 16'h0010, 1, 0, 0, 16'd11, 8'd2);
    vecs[14] = v(0, 0, 9'h000, 1, 16'hFFFF, 0, 16'hFFFF, 1, 0, 0, 16'd12, 8'd3);
    vecs[15] = v(0, 0, 9'h000, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'd13, 8'd3);
    vecs[16] = v(0, 0, H,      1, 16'h0500, 1, 16'h0000, 0, 1, 0, 16'd14, 8'd3);
    vecs[17] = v(0, 0, 9'h000, 1, 16'h0500, 1, 16'h0000, 0, 1, 0, 16'd14, 8'd3);
    vecs[18] = v(1, 3, 9'h000, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'd14, 8'd3);
    vecs[19] = v(1, 2, 9'h000, 0, 16'h0000, 0, 16'h0100, 1, 0, 0, 16'd0,  8'd0);
    vecs[20] = v(0, 0, H,      0, 16'h0000, 0, 16'h0100, 0, 1, 0, 16'd1,  8'd0);
    vecs[21] = v(1, 0, 9'h000, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'd0,  8'd0);

    Reset = 1'b1;
    drive(0, 0, 9'h000, 0, 16'h0000, 0);
    #2;
    chk_a("rst", 16'h0000, 0, 0, 0, 16'd0, 8'd0);
    chk_b("rst_lim", 16'h0000, 0, 0, 0, 16'd0);
    step();
    Reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].start, vecs[i].sel, vecs[i].instr, vecs[i].jmp, vecs[i].tgt, vecs[i].mw);
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].pc, vecs[i].busy, vecs[i].done,
            vecs[i].tmo, vecs[i].cyc, vecs[i].jc);
    end

    // JumpCount saturation: 256 taken jumps after a fresh start
    drive(0, 0, 9'h000, 1, 16'h0020, 0);
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 254) chk("sat254.jc", jc_a, 8'd254);
      if (i == 255) chk("sat255.jc", jc_a, 8'hFF);
    end
    chk_a("sat256", 16'h0020, 1, 0, 0, 16'd256, 8'hFF);

    // Cycle limit of 5 on dut_lim
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    drive(1, 0, 9'h000, 0, 16'h0000, 0);
    step();
    chk_b("lim_start", 16'h0000, 1, 0, 0, 16'd0);
    drive(0, 0, 9'h000, 0, 16'h0000, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_b($sformatf("lim_run%0d", k), 16'(k), 1, 0, 0, 16'(k));
    end
    step();
    chk_b("lim_to", 16'h0005, 0, 1, 1, 16'd5);
    drive(0, 0, 9'h000, 1, 16'h0333, 1);
    step();
    chk_b("lim_hold", 16'h0005, 0, 1, 1, 16'd5);
    drive(1, 2, 9'h000, 0, 16'h0000, 0);
    step();
    chk_b("lim_restart", 16'h0100, 1, 0, 0, 16'd0);
    drive(0, 0, 9'h000, 0, 16'h0000, 0);
    repeat (5) step();
    chk_b("lim_run5b", 16'h0105, 1, 0, 0, 16'd5);
    drive(0, 0, H, 0, 16'h0000, 0);
    step();
    chk_b("lim_halt_wins", 16'h0105, 0, 1, 0, 16'd6);

    // Asynchronous reset in the middle of RUN
    drive(1, 0, 9'h000, 0, 16'h0000, 0);
    step();
    drive(0, 0, 9'h000, 1, 16'h0042, 0);
    step();
    chk_a("pre_rst", 16'h0042, 1, 0, 0, 16'd1, 8'd1);
    drive(0, 0, 9'h000, 0, 16'h0000, 0);
    Reset = 1'b1;
    #1;
    chk_a("async_rst", 16'h0000, 0, 0, 0, 16'd0, 8'd0);
    #1;
    Reset = 1'b0;
    drive(1, 3, 9'h000, 0, 16'h0000, 0);
    repeat (2) step();
    chk_a("post_rst_sel3", 16'h0000, 0, 0, 0, 16'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
